// File: rtl/seq_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3), optional two's-complement input.
// Latency WIDTH+1 cycles from the accepting edge to done; start is ignored while busy.
module seq_bcd_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg
);

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int k = 0; k < n; k++) r = r * 64'd10;
        return r;
    endfunction

    localparam longint unsigned MAX_MAG = (SIGNED != 0) ? (64'd1 << (WIDTH - 1))
                                                        : ((64'd1 << WIDTH) - 64'd1);
    localparam int CW = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
            $fatal(1, "seq_bcd_converter: WIDTH must be within 4..32");
        end
        if (pow10(DIGITS) <= MAX_MAG) begin : g_bad_digits
            $fatal(1, "seq_bcd_converter: DIGITS too small for the operand range");
        end
    endgenerate

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]          state_q,    state_d;
    logic [WIDTH-1:0]    operand_q,  operand_d;
    logic [4*DIGITS-1:0] scratch_q,  scratch_d;
    logic [CW-1:0]       cnt_q,      cnt_d;
    logic                neg_pend_q, neg_pend_d;
    logic [4*DIGITS-1:0] bcd_q,      bcd_d;
    logic                neg_q,      neg_d;

    logic [4*DIGITS-1:0] scratch_adj;
    logic [4*DIGITS-1:0] scratch_shift;
    logic [WIDTH-1:0]    bin_mag;
    logic                bin_neg;

    // Add-3 correction keeps every digit decimal after the following doubling.
    always_comb begin
        scratch_adj = scratch_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                scratch_adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
        scratch_shift = {scratch_adj[4*DIGITS-2:0], operand_q[WIDTH-1]};
    end

    // The most negative operand negates to itself, which read unsigned is the right magnitude.
    always_comb begin
        bin_neg = (SIGNED != 0) && bin[WIDTH-1];
        bin_mag = bin_neg ? (~bin + WIDTH'(1)) : bin;
    end

    always_comb begin
        state_d    = state_q;
        operand_d  = operand_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        neg_pend_d = neg_pend_q;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_SHIFT;
                    operand_d  = bin_mag;
                    neg_pend_d = bin_neg;
                    scratch_d  = '0;
                    cnt_d      = CW'(WIDTH);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                scratch_d = scratch_shift;
                operand_d = {operand_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    bcd_d   = scratch_shift;
                    neg_d   = neg_pend_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            operand_q  <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            neg_pend_q <= 1'b0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            operand_q  <= operand_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            neg_pend_q <= neg_pend_d;
            bcd_q      <= bcd_d;
            neg_q      <= neg_d;
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign bcd  = bcd_q;
    assign neg  = neg_q;

endmodule

// File: tb/tb_seq_bcd_converter.sv
// Bench for seq_bcd_converter: four configurations side by side, a decimal reference model
// compared every cycle, and directed conversions with hand-computed results.
module tb_seq_bcd_converter;

    localparam int NI = 4;
    localparam int W_A [NI] = '{8, 5, 8, 16};
    localparam int S_A [NI] = '{0, 0, 1, 0};

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NI-1:0]     start_v = '0;
    logic [NI-1:0][15:0] bin_v = '0;
    logic [NI-1:0]     busy_a, done_a, neg_a;
    logic [NI-1:0][19:0] bcd_a;
    logic [11:0]       bcd0, bcd2;
    logic [7:0]        bcd1;
    logic [19:0]       bcd3;

    int vectors = 0;
    int misc = 0;
    int cycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    seq_bcd_converter #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) u0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .bin(bin_v[0][7:0]),
        .busy(busy_a[0]), .done(done_a[0]), .bcd(bcd0), .neg(neg_a[0]));
    seq_bcd_converter #(.WIDTH(5), .DIGITS(2), .SIGNED(0)) u1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .bin(bin_v[1][4:0]),
        .busy(busy_a[1]), .done(done_a[1]), .bcd(bcd1), .neg(neg_a[1]));
    seq_bcd_converter #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .bin(bin_v[2][7:0]),
        .busy(busy_a[2]), .done(done_a[2]), .bcd(bcd2), .neg(neg_a[2]));
    seq_bcd_converter #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u3 (
        .clk(clk), .reset(reset), .start(start_v[3]), .bin(bin_v[3]),
        .busy(busy_a[3]), .done(done_a[3]), .bcd(bcd3), .neg(neg_a[3]));

    assign bcd_a[0] = {8'd0, bcd0};
    assign bcd_a[1] = {12'd0, bcd1};
    assign bcd_a[2] = {8'd0, bcd2};
    assign bcd_a[3] = bcd3;

    // Reference model: decimal value of the operand magnitude, released WIDTH edges after acceptance.
    int          m_left   [NI] = '{default: 0};
    int          pend_val [NI] = '{default: 0};
    bit          pend_neg [NI] = '{default: 0};
    bit          m_done   [NI] = '{default: 0};
    bit          m_neg    [NI] = '{default: 0};
    logic [19:0] m_bcd    [NI] = '{default: '0};

    function automatic logic [19:0] dec2bcd(input int v);
        logic [19:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NI; i++) begin
                m_left[i] = 0; m_done[i] = 0; m_neg[i] = 0; m_bcd[i] = '0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                int b;
                m_done[i] = 0;
                if (m_left[i] > 0) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_done[i] = 1;
                        m_bcd[i]  = dec2bcd(pend_val[i]);
                        m_neg[i]  = pend_neg[i];
                    end
                end else if (start_v[i]) begin
                    b = int'(bin_v[i]) & ((1 << W_A[i]) - 1);
                    pend_neg[i] = (S_A[i] != 0) && (b >= (1 << (W_A[i] - 1)));
                    pend_val[i] = pend_neg[i] ? ((1 << W_A[i]) - b) : b;
                    m_left[i] = W_A[i];
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            check($sformatf("model inst%0d {busy,done,neg,bcd}", i),
                  {9'd0, busy_a[i], done_a[i], neg_a[i], bcd_a[i]},
                  {9'd0, (m_left[i] > 0), m_done[i], m_neg[i], m_bcd[i]});
        end
    end

    task automatic wait_done(input int i, output int cyc, output bit ok);
        ok = 0;
        cyc = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (done_a[i]) begin
                ok = 1;
                cyc = cycle;
                return;
            end
        end
    endtask

    // One conversion with junk on bin and a stray start pulse while busy.
    task automatic run_conv(input int i, input int val, input logic [19:0] exp_bcd, input bit exp_neg);
        int nb;
        bit got;
        nb = 0;
        got = 0;
        @(negedge clk);
        start_v[i] = 1'b1;
        bin_v[i] = 16'(val);
        @(negedge clk);
        start_v[i] = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (done_a[i]) begin
                got = 1;
                break;
            end
            if (busy_a[i]) nb++;
            start_v[i] = (nb == 3);
            bin_v[i] = 16'($urandom);
            @(negedge clk);
        end
        start_v[i] = 1'b0;
        check($sformatf("inst%0d bin=%0h done seen", i, val), 32'(got), 32'd1);
        check($sformatf("inst%0d bin=%0h busy cycles", i, val), 32'(nb), 32'(W_A[i]));
        check($sformatf("inst%0d bin=%0h bcd", i, val), 32'(bcd_a[i]), 32'(exp_bcd));
        check($sformatf("inst%0d bin=%0h neg", i, val), 32'(neg_a[i]), 32'(exp_neg));
    endtask

    initial begin
        int c1, c2, v;
        bit ok, seen;

        #1;
        check("reset state busy", 32'(busy_a), 32'd0);
        check("reset state done", 32'(done_a), 32'd0);
        check("reset state neg", 32'(neg_a), 32'd0);
        check("reset state bcd inst3", 32'(bcd_a[3]), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_conv(0, 255, 20'h255, 1'b0);
        run_conv(0, 0, 20'h000, 1'b0);
        run_conv(0, 100, 20'h100, 1'b0);

        for (int n = 0; n < 32; n++) begin
            run_conv(1, n, 20'(((n / 10) << 4) | (n % 10)), 1'b0);
        end
        run_conv(1, 31, 20'h31, 1'b0);
        run_conv(1, 10, 20'h10, 1'b0);
        run_conv(1, 9, 20'h09, 1'b0);

        run_conv(2, 'h80, 20'h128, 1'b1);
        run_conv(2, 'hF6, 20'h010, 1'b1);
        run_conv(2, 'h00, 20'h000, 1'b0);
        run_conv(2, 'h7F, 20'h127, 1'b0);
        run_conv(2, 'hFF, 20'h001, 1'b1);

        run_conv(3, 'hFFFF, 20'h65535, 1'b0);
        run_conv(3, 'h8000, 20'h32768, 1'b0);
        for (int n = 0; n < 16; n++) begin
            v = $urandom_range(0, 65535);
            run_conv(3, v, dec2bcd(v), 1'b0);
        end

        // Back-to-back with start held high: operand sampled only at acceptance.
        @(negedge clk);
        start_v[0] = 1'b1;
        bin_v[0] = 16'd200;
        @(negedge clk);
        bin_v[0] = 16'd7;
        wait_done(0, c1, ok);
        check("held start first done seen", 32'(ok), 32'd1);
        check("held start first bcd", 32'(bcd_a[0]), 32'h200);
        wait_done(0, c2, ok);
        start_v[0] = 1'b0;
        check("held start second done seen", 32'(ok), 32'd1);
        check("held start second bcd", 32'(bcd_a[0]), 32'h007);
        check("held start done spacing", 32'(c2 - c1), 32'd9);

        // Reset in the fourth shift cycle aborts the conversion.
        @(negedge clk);
        start_v[0] = 1'b1;
        bin_v[0] = 16'd255;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset busy", 32'(busy_a[0]), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async reset busy", 32'(busy_a[0]), 32'd0);
        check("async reset done", 32'(done_a[0]), 32'd0);
        check("async reset bcd", 32'(bcd_a[0]), 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (done_a[0]) seen = 1;
        end
        check("no done after abort", 32'(seen), 32'd0);
        run_conv(0, 99, 20'h099, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_bcd_converter.md
SEQ_BCD_CONVERTER -- requirements
Module: seq_bcd_converter

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, binary operand width (legal range 4..32).
REQ-002 SHALL provide parameter DIGITS, default 3, BCD digit count; elaboration SHALL fail if 10^DIGITS <= 2^WIDTH-1 (or <= 2^(WIDTH-1) when SIGNED=1).
REQ-003 SHALL provide parameter SIGNED, default 0: 0 = unsigned operand, 1 = two's-complement operand.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request conversion of bin; honoured only when busy=0.
REQ-007 bin  input  WIDTH  binary operand, sampled on the accepting edge only.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  one-cycle pulse: bcd/neg hold a new result.
REQ-010 bcd  output  4*DIGITS  packed BCD result, digit 0 (units) in bits [3:0].
REQ-011 neg  output  1  operand was negative (always 0 when SIGNED=0).

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE; busy=1 only in SHIFT.
REQ-013 IDLE/DONE with start=1 -> SHIFT; operand register <= bin (SIGNED=1 and bin MSB=1: two's-complement magnitude, neg_pending=1); digit scratch cleared; bit counter <= WIDTH.
REQ-014 IDLE with start=0 -> IDLE; DONE with start=0 -> IDLE.
REQ-015 Each SHIFT cycle: every scratch digit >= 5 gets +3, then {scratch, operand} shifts left one bit; counter decrements.
REQ-016 SHIFT SHALL last exactly WIDTH cycles, then -> DONE.
REQ-017 Entering DONE, bcd <= scratch and neg <= neg_pending; done=1 for exactly the DONE cycle.
REQ-018 Latency: done high on the (WIDTH+1)th rising edge after the accepting edge; one conversion per WIDTH+1 cycles with start held high.
REQ-019 bcd/neg SHALL hold the last result until the next DONE; never show partial scratch values.
REQ-020 start while busy=1 SHALL be ignored, no queueing; bin changes during SHIFT SHALL not affect the result.
REQ-021 Every output digit SHALL be 0..9; upper unused digits SHALL be 0.
REQ-022 SIGNED=1, bin = -2^(WIDTH-1): magnitude 2^(WIDTH-1) converted correctly, neg=1.
REQ-023 Operand zero SHALL give bcd all zero, neg=0 (SIGNED=1 included).

Reset
REQ-024 reset=1 SHALL immediately force state IDLE, busy=0, done=0, bcd=0, neg=0, counter=0, scratch=0, independent of clk.
REQ-025 reset during SHIFT SHALL abort the conversion; no done pulse for the aborted request.
REQ-026 After reset deasserts, first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-027 WIDTH=8,DIGITS=3,SIGNED=0: start with bin=8'd255 -> busy for 8 cycles, done on 9th edge, bcd=12'h255, neg=0.
REQ-028 WIDTH=5,DIGITS=2: sweep bin 0..31 -> bcd equals decimal (e.g. 31 -> 8'h31, 10 -> 8'h10, 9 -> 8'h09).
REQ-029 WIDTH=8,SIGNED=1: bin=8'h80 -> bcd=12'h128, neg=1; bin=8'hF6 -> bcd=12'h010, neg=1; bin=8'h00 -> bcd=0, neg=0.
REQ-030 start held high, bin=200 then 7 -> done pulses exactly 9 cycles apart with bcd=12'h200 then 12'h007; start pulses during busy ignored.
REQ-031 reset asserted mid-SHIFT (cycle 4 of 8) -> busy, done, bcd drop to 0 asynchronously; no done follows; next start bin=99 -> bcd=12'h099.
REQ-032 WIDTH=16,DIGITS=5: bin=16'hFFFF -> bcd=20'h65535 after 17 cycles; random bins checked against a reference decimal model.
